// File: rtl/audio_pkg.sv
// audio_pkg: shared widths and FSM state encoding for the stereo PCM capture path.
package audio_pkg;
    localparam int PCM_W   = 16;
    localparam int FRAME_W = 2 * PCM_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_RUN,
        ST_DRAIN
    } state_t;
endpackage

// File: rtl/audio_frame_fifo.sv
// audio_frame_fifo: synchronous stereo-frame FIFO; pointers carry an extra wrap bit for full/empty.
module audio_frame_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [FRAME_W-1:0]       i_data,
    output logic [FRAME_W-1:0]       o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [FRAME_W-1:0] r_mem [DEPTH];
    logic [AW:0]        r_wr;
    logic [AW:0]        r_rd;
    logic               w_push;
    logic               w_pop;

    assign o_empty = (r_wr == r_rd);
    assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign o_count = r_wr - r_rd;
    assign o_data  = r_mem[r_rd[AW-1:0]];
    assign w_pop   = i_pop && !o_empty;
    // A pop in the same cycle frees the head slot, so a push into a full FIFO is still accepted
    assign w_push  = i_push && (!o_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;
    end
endmodule

// File: rtl/audio_capture_ctrl.sv
// audio_capture_ctrl: sequences PDM capture (warm-up discard, frame buffering) and
// serialises stereo frames onto a valid/ready stream, left word then right word.
module audio_capture_ctrl
    import audio_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int WARMUP = 16,
    parameter int OVF_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_en,
    input  logic                     i_mute,
    input  logic                     i_stb_pcm,
    input  logic signed [PCM_W-1:0]  i_pcm_left,
    input  logic signed [PCM_W-1:0]  i_pcm_right,
    output logic                     o_mic_run,
    output logic                     o_busy,
    output logic                     o_m_valid,
    input  logic                     i_m_ready,
    output logic [PCM_W-1:0]         o_m_data,
    output logic                     o_m_right,
    output logic [$clog2(DEPTH):0]   o_fill,
    output logic [OVF_W-1:0]         o_ovf_cnt
);
    localparam int                WC_W   = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam logic [WC_W-1:0]   W_LAST = WC_W'((WARMUP > 0) ? WARMUP - 1 : 0);

    state_t             r_state;
    state_t             w_state;
    logic [WC_W-1:0]    r_wcnt;
    logic [OVF_W-1:0]   r_ovf;
    logic               r_right;
    logic               w_start;
    logic               w_push;
    logic               w_pop;
    logic               w_xfer;
    logic               w_full;
    logic               w_empty;
    logic [FRAME_W-1:0] w_frame;
    logic [FRAME_W-1:0] w_head;

    assign w_frame   = i_mute ? '0 : {i_pcm_left, i_pcm_right};
    assign w_xfer    = o_m_valid && i_m_ready;
    assign w_pop     = w_xfer && r_right;
    assign o_m_valid = !w_empty;
    assign o_m_right = r_right;
    assign o_m_data  = !o_m_valid ? '0 : r_right ? w_head[PCM_W-1:0] : w_head[FRAME_W-1:PCM_W];
    assign o_mic_run = (r_state == ST_WARMUP) || (r_state == ST_RUN);
    assign o_busy    = (r_state != ST_IDLE);
    assign o_ovf_cnt = r_ovf;

    always_comb begin
        w_state = r_state;
        w_start = 1'b0;
        w_push  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_start = i_en;
                if (i_en) w_state = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
            end
            ST_WARMUP: begin
                if (!i_en) w_state = ST_IDLE;
                else if (i_stb_pcm && r_wcnt == W_LAST) w_state = ST_RUN;
            end
            ST_RUN: begin
                if (!i_en) w_state = ST_DRAIN;
                else w_push = i_stb_pcm;
            end
            ST_DRAIN: begin
                if (w_empty) w_state = ST_IDLE;
            end
            default: w_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_wcnt  <= '0;
            r_ovf   <= '0;
            r_right <= 1'b0;
        end else begin
            r_state <= w_state;
            if (w_start) r_wcnt <= '0;
            else if (r_state == ST_WARMUP && i_stb_pcm) r_wcnt <= r_wcnt + 1'b1;
            if (w_start) r_ovf <= '0;
            else if (w_push && w_full && !w_pop && r_ovf != '1) r_ovf <= r_ovf + 1'b1;
            if (w_xfer) r_right <= !r_right;
        end
    end

    audio_frame_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_frame),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (o_fill)
    );
endmodule
